// File: rtl/sort_job_sequencer.sv
// Job-level controller for the BRAM bubble-sort engine: loads a job through the
// engine host port, starts the sort, drains the sorted FIFO to a result stream.
module sort_job_sequencer #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_COUNT = 1024,
  parameter int TIMEOUT   = 2**24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W:0]   cmd_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err,
  output logic [31:0]       sort_cycles,
  output logic              eng_start,
  output logic              eng_wr_en,
  output logic              eng_rd_en,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [DATA_W-1:0] eng_wdata,
  input  logic [DATA_W-1:0] eng_sorted,
  input  logic              eng_done
);

  localparam int               CNT_W      = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_COUNT);
  localparam logic [31:0]      TIMEOUT_M1 = 32'(TIMEOUT - 1);

  // REQ/CAP/HOLD are the three phases of draining one result word.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_SORT, S_REQ, S_CAP, S_HOLD, S_RELEASE
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  n, n_n;
  logic [CNT_W-1:0]  idx, idx_n;
  logic              err_n, eng_wr_en_n, out_last_n;
  logic [ADDR_W-1:0] eng_addr_n;
  logic [DATA_W-1:0] eng_wdata_n, out_data_n;
  logic [31:0]       sort_cycles_n, cycles_inc;

  assign cycles_inc = (&sort_cycles) ? sort_cycles : sort_cycles + 32'd1;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_n       = state;
    n_n           = n;
    idx_n         = idx;
    err_n         = 1'b0;
    eng_wr_en_n   = 1'b0;
    eng_addr_n    = eng_addr;
    eng_wdata_n   = eng_wdata;
    out_data_n    = out_data;
    out_last_n    = out_last;
    sort_cycles_n = sort_cycles;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_count == '0 || cmd_count > MAX_CNT) begin
            err_n = 1'b1;
          end else begin
            n_n     = cmd_count;
            idx_n   = '0;
            state_n = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready) begin
          eng_wr_en_n = 1'b1;
          eng_addr_n  = ADDR_W'(idx);
          eng_wdata_n = in_data;
          idx_n       = idx + 1'b1;
          if (idx_n == n) state_n = S_ARM;
        end
      end
      S_ARM: begin
        eng_addr_n    = ADDR_W'(n - 1'b1);
        sort_cycles_n = '0;
        idx_n         = '0;
        state_n       = S_SORT;
      end
      S_SORT: begin
        if (eng_done) begin
          idx_n   = idx + 1'b1;
          state_n = S_REQ;
        end else if (sort_cycles == TIMEOUT_M1) begin
          sort_cycles_n = cycles_inc;
          err_n         = 1'b1;
          state_n       = S_RELEASE;
        end else begin
          sort_cycles_n = cycles_inc;
        end
      end
      S_REQ: state_n = S_CAP;
      S_CAP: begin
        out_data_n = eng_sorted;
        out_last_n = (idx == n);
        state_n    = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_last_n = 1'b0;
          if (out_last) begin
            state_n = S_RELEASE;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = S_REQ;
          end
        end
      end
      S_RELEASE: if (!eng_done) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Every output is a register loaded from the next-state decision.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      n           <= '0;
      idx         <= '0;
      cmd_ready   <= 1'b1;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      eng_start   <= 1'b0;
      eng_wr_en   <= 1'b0;
      eng_rd_en   <= 1'b0;
      eng_addr    <= '0;
      eng_wdata   <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      sort_cycles <= '0;
    end else begin
      state       <= state_n;
      n           <= n_n;
      idx         <= idx_n;
      cmd_ready   <= (state_n == S_IDLE);
      in_ready    <= (state_n == S_LOAD);
      busy        <= (state_n != S_IDLE);
      err         <= err_n;
      eng_start   <= (state_n inside {S_SORT, S_REQ, S_CAP, S_HOLD});
      eng_wr_en   <= eng_wr_en_n;
      eng_rd_en   <= (state_n == S_REQ);
      eng_addr    <= eng_addr_n;
      eng_wdata   <= eng_wdata_n;
      out_valid   <= (state_n == S_HOLD);
      out_data    <= out_data_n;
      out_last    <= out_last_n;
      sort_cycles <= sort_cycles_n;
    end
  end

endmodule

// File: tb/tb_sort_job_sequencer.sv
// Directed bench for sort_job_sequencer with a behavioural sort engine
// that updates on the falling edge.
module tb_sort_job_sequencer;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int MAX_COUNT = 1024;
  localparam int TIMEOUT   = 100;
  localparam int SORT_LAT  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W:0]   cmd_count;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              err;
  logic [31:0]       sort_cycles;
  logic              eng_start;
  logic              eng_wr_en;
  logic              eng_rd_en;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_wdata;
  logic [DATA_W-1:0] eng_sorted;
  logic              eng_done;

  sort_job_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_COUNT(MAX_COUNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_count(cmd_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err), .sort_cycles(sort_cycles),
    .eng_start(eng_start), .eng_wr_en(eng_wr_en), .eng_rd_en(eng_rd_en),
    .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_sorted(eng_sorted), .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Engine model: BRAM written through the host port, sorted copy queued on start.
  logic [31:0] mem [0:1023];
  logic [31:0] fifo [$];
  logic [31:0] srt  [$];
  logic [31:0] key;
  bit          started;
  bit          hang;
  int          lat;
  int          j;

  initial begin
    eng_done   = 1'b0;
    eng_sorted = '0;
    started    = 0;
    lat        = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        started  = 0;
        eng_done = 1'b0;
        fifo.delete();
      end else begin
        if (eng_wr_en) mem[eng_addr] = eng_wdata;
        if (eng_rd_en) eng_sorted = (fifo.size() > 0) ? fifo.pop_front() : 32'hBAD0BAD0;
        if (!eng_start) begin
          started  = 0;
          eng_done = 1'b0;
        end else begin
          if (!started) begin
            started = 1;
            lat     = SORT_LAT;
            srt.delete();
            for (int i = 0; i <= int'(eng_addr); i++) srt.push_back(mem[i]);
            for (int i = 1; i < srt.size(); i++) begin
              key = srt[i];
              j   = i - 1;
              while (j >= 0 && srt[j] > key) begin
                srt[j+1] = srt[j];
                j--;
              end
              srt[j+1] = key;
            end
            fifo.delete();
            foreach (srt[i]) fifo.push_back(srt[i]);
          end else if (lat > 0) begin
            lat--;
          end
          eng_done = (lat == 0) && !hang;
        end
      end
    end
  end

  // Protocol monitor sampled on the falling edge.
  int          rd_cnt = 0, rd_while_valid = 0, wr_cnt = 0, start_cnt = 0;
  int          clash_cnt = 0, err_cnt = 0, ov_rise = 0, unstable = 0;
  logic [31:0] wr_addr_log [$];
  logic [31:0] wr_data_log [$];
  logic        ov_prev = 1'b0, rdy_prev = 1'b0, last_prev = 1'b0;
  logic [31:0] d_prev = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (eng_rd_en) rd_cnt++;
      if (eng_rd_en && out_valid) rd_while_valid++;
      if (eng_start) start_cnt++;
      if (eng_wr_en && eng_start) clash_cnt++;
      if (err) err_cnt++;
      if (eng_wr_en) begin
        wr_cnt++;
        wr_addr_log.push_back(32'(eng_addr));
        wr_data_log.push_back(eng_wdata);
      end
      if (out_valid && !ov_prev) ov_rise++;
      if (ov_prev && !rdy_prev && out_valid && (out_data !== d_prev || out_last !== last_prev))
        unstable++;
      ov_prev   = out_valid;
      rdy_prev  = out_ready;
      d_prev    = out_data;
      last_prev = out_last;
    end
  end

  logic [31:0] in_q  [$];
  logic [31:0] exp_q [$];

  task automatic do_cmd(input int c);
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin tick; t++; end
    cmd_count = 11'(c);
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic load_n(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int t = 0;
      in_data  = in_q[i];
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && t < 50) begin tick; t++; end
      check("in_ready", 32'(in_ready), 32'd1);
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int duty);
    for (int i = 0; i < exp_q.size(); i++) begin
      int t = 0;
      while (out_valid !== 1'b1 && t < 60) begin tick; t++; end
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_data", out_data, exp_q[i]);
      check("out_last", 32'(out_last), (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
      for (int k = 0; k < 1000; k++) begin
        bit r;
        r = ($urandom_range(0, 99) < duty);
        out_ready = r;
        tick;
        if (r) break;
      end
      out_ready = 1'b0;
    end
  endtask

  task automatic wait_idle;
    int t = 0;
    while (busy !== 1'b0 && t < 40) begin tick; t++; end
    check("busy_falls", 32'(busy), 32'd0);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
  endtask

  int w0, rd0, e0, s0, ov0;

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_count = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    hang      = 0;
    tick;
    tick;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_wr_rd", {30'd0, eng_wr_en, eng_rd_en}, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_sort_cycles", sort_cycles, 32'd0);
    reset = 1'b0;
    tick;
    check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // Four-word job.
    w0 = wr_addr_log.size(); rd0 = rd_cnt; e0 = err_cnt;
    in_q = '{32'd5, 32'd3, 32'd9, 32'd1};
    do_cmd(4);
    check("busy_after_cmd", 32'(busy), 32'd1);
    load_n(4);
    begin
      int t = 0;
      while (eng_start !== 1'b1 && t < 20) begin tick; t++; end
    end
    check("start_seen", 32'(eng_start), 32'd1);
    check("sort_addr", 32'(eng_addr), 32'd3);
    check("no_wr_in_sort", 32'(eng_wr_en), 32'd0);
    check("wr_count4", wr_addr_log.size() - w0, 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("wr_addr", wr_addr_log[w0+k], 32'(k));
      check("wr_data", wr_data_log[w0+k], in_q[k]);
    end
    exp_q = '{32'd1, 32'd3, 32'd5, 32'd9};
    drain(100);
    check("sort_cycles4", sort_cycles, 32'(SORT_LAT));
    wait_idle;
    check("rd_count4", rd_cnt - rd0, 32'd4);
    check("no_err4", err_cnt - e0, 32'd0);

    // Single-word job.
    rd0 = rd_cnt; e0 = err_cnt;
    in_q = '{32'hDEADBEEF};
    do_cmd(1);
    load_n(1);
    exp_q = '{32'hDEADBEEF};
    drain(100);
    check("sort_cycles1", sort_cycles, 32'(SORT_LAT));
    wait_idle;
    check("rd_count1", rd_cnt - rd0, 32'd1);
    check("no_err1", err_cnt - e0, 32'd0);

    // Illegal counts.
    e0 = err_cnt; w0 = wr_cnt; s0 = start_cnt;
    do_cmd(0);
    check("err_cnt0", 32'(err), 32'd1);
    check("cmd_ready_cnt0", 32'(cmd_ready), 32'd1);
    check("busy_cnt0", 32'(busy), 32'd0);
    tick;
    check("err_pulse_cnt0", 32'(err), 32'd0);
    do_cmd(1025);
    check("err_cnt1025", 32'(err), 32'd1);
    check("cmd_ready_cnt1025", 32'(cmd_ready), 32'd1);
    tick;
    tick;
    check("err_pulses", err_cnt - e0, 32'd2);
    check("bad_no_wr", wr_cnt - w0, 32'd0);
    check("bad_no_start", start_cnt - s0, 32'd0);
    check("bad_busy", 32'(busy), 32'd0);

    // Full-size descending job with random back-pressure.
    rd0 = rd_cnt;
    in_q.delete();
    exp_q.delete();
    for (int i = 0; i < 1024; i++) begin
      in_q.push_back(32'(1023 - i));
      exp_q.push_back(32'(i));
    end
    do_cmd(1024);
    load_n(1024);
    drain(50);
    check("sort_cycles1024", sort_cycles, 32'(SORT_LAT));
    wait_idle;
    check("rd_count1024", rd_cnt - rd0, 32'd1024);
    check("rd_while_valid", rd_while_valid, 32'd0);
    check("stall_stable", unstable, 32'd0);
    check("wr_start_clash", clash_cnt, 32'd0);

    // Watchdog: engine never finishes.
    hang = 1;
    ov0  = ov_rise;
    in_q = '{32'd10, 32'd20};
    do_cmd(2);
    load_n(2);
    begin
      int t = 0;
      while (err !== 1'b1 && t < 400) begin tick; t++; end
    end
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_cycles", sort_cycles, 32'(TIMEOUT));
    check("timeout_start_low", 32'(eng_start), 32'd0);
    wait_idle;
    check("timeout_no_out", ov_rise - ov0, 32'd0);
    hang = 0;

    // Reset in the middle of a load, with a command offered during reset.
    in_q = '{32'd4, 32'd3, 32'd2, 32'd1};
    do_cmd(4);
    load_n(2);
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_count = 11'd4;
    tick;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_strobes", {29'd0, eng_start, eng_wr_en, eng_rd_en}, 32'd0);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    tick;
    check("rst_cmd_not_taken", 32'(busy), 32'd0);
    in_q = '{32'd7, 32'd2, 32'd8, 32'd4};
    do_cmd(4);
    load_n(4);
    exp_q = '{32'd2, 32'd4, 32'd7, 32'd8};
    drain(70);
    check("sort_cycles_fresh", sort_cycles, 32'(SORT_LAT));
    wait_idle;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sort_job_sequencer.md
# sort_job_sequencer

Job-level controller that sits between a streaming host interface and the BRAM bubble-sort engine. It accepts a job command, loads the words into engine BRAM through the engine's host write port, and starts the sort. When the engine reports done, it drains the engine's output FIFO to a valid/ready result stream and releases the engine back to idle. It also reports busy status, a per-job sort cycle count, and error conditions (bad count, watchdog timeout).

## Interface
Parameters:
- ADDR_W, 10, engine BRAM address width
- DATA_W, 32, data word width
- MAX_COUNT, 1024, largest legal job length (2**ADDR_W)
- TIMEOUT, 2**24, watchdog limit in cycles for SORT state

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  job command offered
- cmd_ready  out  1  high in IDLE only
- cmd_count  in  ADDR_W+1  number of words in job, legal 1..MAX_COUNT
- in_valid / in_ready  in / out  1  load-stream handshake
- in_data  in  DATA_W  unsorted word
- out_valid / out_ready  out / in  1  result-stream handshake
- out_data  out  DATA_W  sorted word, ascending unsigned
- out_last  out  1  high with final result word
- busy  out  1  high in any state except IDLE
- err  out  1  one-cycle pulse: bad count or timeout
- sort_cycles  out  32  cycles spent in SORT for the last job, held until next job
- eng_start  out  1  engine start/mux select
- eng_wr_en  out  1  engine host write strobe
- eng_rd_en  out  1  engine FIFO read strobe
- eng_addr  out  ADDR_W  host address: write index during LOAD, count-1 during ARM..RELEASE
- eng_wdata  out  DATA_W  host write data
- eng_sorted  in  DATA_W  engine FIFO output, valid 1 cycle after eng_rd_en
- eng_done  in  1  engine done flag

## Operation
- All outputs are registered. Reset clears state to IDLE and all outputs to 0 except cmd_ready. cmd_ready is 1 one cycle after reset deasserts.
- IDLE: cmd_ready=1.
  - Command handshake with cmd_count in 1..MAX_COUNT: latch N=cmd_count and clear the index. Go to LOAD.
  - Illegal count (0 or >MAX_COUNT): consume the command, pulse err, stay in IDLE.
- LOAD: in_ready=1.
  - Each in handshake: next cycle eng_wr_en=1, eng_addr=index, eng_wdata=in_data. Index then increments.
  - After the N-th word, in_ready drops and the state goes to ARM.
  - eng_start stays 0 throughout LOAD.
- ARM (1 cycle): eng_wr_en=0, eng_addr=N-1, eng_start=1. Go to SORT.
- SORT: eng_start=1 and eng_addr=N-1 held constant.
  - sort_cycles counter starts from 0 and increments every cycle.
  - eng_done=1: freeze sort_cycles and go to DRAIN.
  - Counter reaches TIMEOUT: pulse err and go to RELEASE with nothing drained.
- DRAIN: eng_start stays 1. Each word is read in three cycles, N words total:
  - REQ: eng_rd_en=1 for one cycle.
  - CAP: the next cycle, out_data<=eng_sorted and out_valid<=1. out_last=1 on word N.
  - HOLD: out_valid held until out_ready. On the handshake, out_valid drops and the next REQ issues the following cycle.
  - After the last handshake, go to RELEASE.
- RELEASE: eng_start=0, eng_wr_en=0, eng_rd_en=0. Wait until eng_done=0, then go to IDLE.
- Engine requirements: FIFO depth ≥ MAX_COUNT. eng_wr_en is never 1 while eng_start=1.
- Commands arriving while busy are held off by cmd_ready=0. They are never dropped.
- Reset mid-job: return to IDLE in one cycle with all strobes low. The engine shares the same reset.

## Timing
- Load rate: 1 word/cycle with in_valid held high. Write strobe lags the handshake by exactly 1 cycle.
- ARM to SORT: eng_start rises 1 cycle after the last write strobe.
- Drain rate: at most 1 word per 3 cycles (REQ, CAP, handshake). out_valid rises 2 cycles after eng_rd_en.
- Back-pressure: out_ready may be low indefinitely. out_data and out_last stay stable while out_valid=1 and out_ready=0.
- No eng_rd_en is issued while out_valid=1. Exactly N FIFO reads occur per completed job.
- Simultaneous cmd_valid and reset: reset wins and the command is not accepted.
- N=1: LOAD, ARM and SORT as normal. Exactly one result with out_last=1.
- sort_cycles width 32 saturates at 2**32-1. It is unaffected by DRAIN back-pressure.

## Test plan
- Load [5,3,9,1] with cmd_count=4 -> writes at addresses 0..3, eng_addr=3 in SORT, out stream 1,3,5,9 with out_last on 9, busy falls after eng_done drops.
- cmd_count=1, data 0xDEADBEEF -> single output 0xDEADBEEF with out_last=1, no err.
- cmd_count=0, then cmd_count=1025 -> err pulses once per command, no eng_wr_en or eng_start activity, cmd_ready stays 1.
- Job of 1024 descending words, random out_ready duty -> 1024 ascending outputs, each output word stable under stall, exactly 1024 eng_rd_en pulses, no eng_rd_en while out_valid=1.
- Engine model never raises eng_done, TIMEOUT=100 -> err at SORT cycle 100, eng_start drops, state returns to IDLE, zero out_valid pulses.
- Reset asserted mid-LOAD after 2 of 4 words -> next cycle busy=0, all strobes 0, cmd_ready=1. A fresh job then completes correctly.
